// File: rtl/joybus_pkg.sv
// Shared types and default timing for the joybus controller-port poll scheduler.
package joybus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } sched_state_t;

    localparam int unsigned TIMEOUT_US_DEF = 400;
    localparam int unsigned GAP_US_DEF     = 20;
    localparam int unsigned MISS_LIMIT_DEF = 3;
    localparam int unsigned PERIOD_W       = 16;

endpackage

// File: rtl/joybus_poll_scheduler_if.sv
// Bundle between game logic / transceivers and the poll scheduler.
interface joybus_poll_scheduler_if #(
    parameter int unsigned NPORTS = 4
);
    import joybus_pkg::*;

    localparam int unsigned AW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic                enable;
    logic [PERIOD_W-1:0] period_us;
    logic [NPORTS-1:0]   port_mask;
    logic [NPORTS-1:0]   rumble_req;
    logic [NPORTS-1:0]   port_done;
    logic [NPORTS-1:0]   port_poll;
    logic [NPORTS-1:0]   port_rumble;
    logic [NPORTS-1:0]   connected;
    logic                busy;
    logic [AW-1:0]       active_port;
    logic                frame_tick;
    logic                overrun;

    // Scheduler side
    modport master (
        input  enable, period_us, port_mask, rumble_req, port_done,
        output port_poll, port_rumble, connected, busy, active_port, frame_tick, overrun
    );

    // Game logic / transceiver side
    modport slave (
        output enable, period_us, port_mask, rumble_req, port_done,
        input  port_poll, port_rumble, connected, busy, active_port, frame_tick, overrun
    );

endinterface

// File: rtl/joybus_frame_timer.sv
// Free-running frame period counter; frame_due_c pulses on the last cycle of each period.
module joybus_frame_timer #(
    parameter int unsigned PW = 16
) (
    input  logic          usClock,
    input  logic          Reset,
    input  logic          enable,
    input  logic [PW-1:0] period_us,
    output logic          frame_due_c
);

    logic [PW-1:0] cnt;
    logic          run;
    logic          wrap;

    assign run  = enable && (period_us != '0);
    // >= so a shrinking period wraps immediately instead of rolling over 2^PW
    assign wrap = run && (cnt >= (period_us - PW'(1)));
    assign frame_due_c = wrap;

    always_ff @(posedge usClock) begin
        if (Reset || !run || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/joybus_poll_scheduler.sv
// Round-robin poll sequencer for the per-port joybus transceivers: one poll per
// masked-in port per frame, response/timeout wait, bus-quiet gap, connection tracking.
module joybus_poll_scheduler
    import joybus_pkg::*;
#(
    parameter int unsigned NPORTS     = 4,
    parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
    parameter int unsigned GAP_US     = GAP_US_DEF,
    parameter int unsigned MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  logic                   usClock,
    input  logic                   Reset,
    joybus_poll_scheduler_if.master bus
);

    localparam int unsigned AW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned CW = 16;
    localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

    sched_state_t      state, state_n;
    logic [AW-1:0]     port_n;
    logic [CW-1:0]     tcnt, tcnt_n;
    logic [CW-1:0]     gcnt, gcnt_n;
    logic              pending, pending_n;
    logic              overrun_n;
    logic              tick_n;
    logic [NPORTS-1:0] poll_n, rumble_n, conn_n;
    logic [MW-1:0]     miss   [NPORTS];
    logic [MW-1:0]     miss_n [NPORTS];
    logic [AW:0]       nxt;
    logic              frame_due_c;

    joybus_frame_timer #(.PW(PERIOD_W)) u_frame_timer (
        .usClock     (usClock),
        .Reset       (Reset),
        .enable      (bus.enable),
        .period_us   (bus.period_us),
        .frame_due_c (frame_due_c)
    );

    // Lowest masked-in port at index >= from; MSB flags that one was found.
    function automatic logic [AW:0] next_port(input logic [NPORTS-1:0] mask, input int from);
        logic [AW:0] r;
        r = '0;
        for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                r = {1'b1, AW'(i)};
            end
        end
        return r;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        port_n    = bus.active_port;
        tcnt_n    = tcnt;
        gcnt_n    = gcnt;
        pending_n = pending;
        overrun_n = bus.overrun;
        tick_n    = 1'b0;
        poll_n    = '0;
        rumble_n  = bus.port_rumble;
        conn_n    = bus.connected;
        miss_n    = miss;
        nxt       = '0;

        if (frame_due_c && (state != IDLE)) begin
            pending_n = 1'b1;
            overrun_n = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (!bus.enable) begin
                    pending_n = 1'b0;
                end else if (frame_due_c || pending) begin
                    pending_n = 1'b0;
                    nxt       = next_port(bus.port_mask, 0);
                    if (nxt[AW]) begin
                        state_n = ISSUE;
                        port_n  = nxt[AW-1:0];
                    end else begin
                        tick_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT_DONE;
                tcnt_n  = CW'(1);
            end
            WAIT_DONE: begin
                // A response in the timeout cycle still counts as an answer
                if (bus.port_done[bus.active_port]) begin
                    conn_n[bus.active_port] = 1'b1;
                    miss_n[bus.active_port] = '0;
                    state_n = GAP;
                    gcnt_n  = CW'(1);
                end else if (tcnt >= CW'(TIMEOUT_US)) begin
                    if (miss[bus.active_port] < MW'(MISS_LIMIT)) begin
                        miss_n[bus.active_port] = miss[bus.active_port] + MW'(1);
                    end
                    if (miss_n[bus.active_port] >= MW'(MISS_LIMIT)) begin
                        conn_n[bus.active_port] = 1'b0;
                    end
                    state_n = GAP;
                    gcnt_n  = CW'(1);
                end else begin
                    tcnt_n = tcnt + CW'(1);
                end
            end
            GAP: begin
                if (gcnt >= CW'(GAP_US)) begin
                    nxt = next_port(bus.port_mask, int'(bus.active_port) + 1);
                    if (!bus.enable) begin
                        state_n   = IDLE;
                        pending_n = 1'b0;
                    end else if (nxt[AW]) begin
                        state_n = ISSUE;
                        port_n  = nxt[AW-1:0];
                    end else begin
                        state_n = IDLE;
                        tick_n  = 1'b1;
                    end
                end else begin
                    gcnt_n = gcnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Poll pulse and rumble latch coincide with the ISSUE cycle
        if (state_n == ISSUE) begin
            poll_n[port_n]   = 1'b1;
            rumble_n[port_n] = bus.rumble_req[port_n];
        end
    end

    // State and registered outputs
    always_ff @(posedge usClock) begin
        if (Reset) begin
            state           <= IDLE;
            tcnt            <= '0;
            gcnt            <= '0;
            pending         <= 1'b0;
            bus.port_poll   <= '0;
            bus.port_rumble <= '0;
            bus.connected   <= '0;
            bus.busy        <= 1'b0;
            bus.active_port <= '0;
            bus.frame_tick  <= 1'b0;
            bus.overrun     <= 1'b0;
            for (int i = 0; i < int'(NPORTS); i++) begin
                miss[i] <= '0;
            end
        end else begin
            state           <= state_n;
            tcnt            <= tcnt_n;
            gcnt            <= gcnt_n;
            pending         <= pending_n;
            bus.port_poll   <= poll_n;
            bus.port_rumble <= rumble_n;
            bus.connected   <= conn_n;
            bus.busy        <= (state_n != IDLE);
            bus.active_port <= port_n;
            bus.frame_tick  <= tick_n;
            bus.overrun     <= overrun_n;
            for (int i = 0; i < int'(NPORTS); i++) begin
                miss[i] <= miss_n[i];
            end
        end
    end

endmodule

// File: tb/tb_joybus_poll_scheduler.sv
// Scoreboard bench for joybus_poll_scheduler: expected poll/frame_tick events with cycle stamps.
module tb_joybus_poll_scheduler;

    localparam int RESP_DLY = 101;
    localparam int SPC_ANS  = 1 + RESP_DLY + 20;
    localparam int SPC_MISS = 1 + 400 + 20;

    typedef struct {
        logic [4:0] vec;
        int         cyc;
    } ev_t;

    logic usClock = 1'b0;
    logic Reset   = 1'b1;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  sb[$];
    ev_t  mon_e;
    int   done_at[4];
    logic [3:0] ans_en = 4'h0;
    logic [3:0] pd;

    joybus_poll_scheduler_if #(.NPORTS(4)) bus ();

    joybus_poll_scheduler #(.NPORTS(4)) dut (
        .usClock (usClock),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 usClock = ~usClock;
    always @(posedge usClock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [4:0] vec, input int c);
        ev_t e;
        e.vec = vec;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_poll(input int port, input int c);
        logic [4:0] v;
        v = '0;
        v[port] = 1'b1;
        push_ev(v, c);
    endtask

    // Expected polls of one frame starting at base, then the frame_tick
    task automatic push_frame(input int base, input logic [3:0] msk, input logic [3:0] ans);
        int t;
        t = base;
        for (int i = 0; i < 4; i++) begin
            if (msk[i]) begin
                push_poll(i, t);
                t += ans[i] ? SPC_ANS : SPC_MISS;
            end
        end
        push_ev(5'b10000, t);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge usClock);
            #1;
        end
    endtask

    task automatic do_reset(input logic [15:0] per, input logic [3:0] msk, output int r0);
        Reset = 1'b1;
        bus.enable = 1'b0;
        @(posedge usClock);
        #1;
        check("reset_outputs", {bus.port_poll, bus.port_rumble, bus.connected, bus.busy,
                                bus.active_port, bus.frame_tick, bus.overrun}, 32'd0);
        repeat (2) begin
            @(posedge usClock);
            #1;
        end
        sb.delete();
        bus.period_us  = per;
        bus.port_mask  = msk;
        bus.rumble_req = '0;
        bus.enable     = 1'b1;
        Reset          = 1'b0;
        r0             = cyc;
    endtask

    // Output monitor plus transceiver model answering RESP_DLY cycles after each poll
    initial begin
        bus.port_done = '0;
        for (int i = 0; i < 4; i++) done_at[i] = -1;
        forever begin
            @(posedge usClock);
            #1;
            if (Reset) begin
                for (int i = 0; i < 4; i++) done_at[i] = -1;
                bus.port_done = '0;
            end else begin
                if ((bus.port_poll != '0) || bus.frame_tick) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected", {bus.frame_tick, bus.port_poll}, 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("sb_event", {bus.frame_tick, bus.port_poll}, mon_e.vec);
                        check("sb_cycle", cyc, mon_e.cyc);
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (bus.port_poll[i]) done_at[i] = cyc + RESP_DLY;
                    pd[i] = ans_en[i] && (done_at[i] == cyc);
                end
                bus.port_done = pd;
            end
        end
    end

    initial begin
        int r0;
        int r1;
        bus.enable = 1'b0;
        bus.period_us = '0;
        bus.port_mask = '0;
        bus.rumble_req = '0;

        // All ports answer, two frames
        do_reset(16'd1000, 4'hF, r0);
        ans_en = 4'hF;
        push_frame(r0 + 1000, 4'hF, 4'hF);
        push_frame(r0 + 2000, 4'hF, 4'hF);
        wait_until(r0 + 500);
        check("a_idle_busy", bus.busy, 0);
        wait_until(r0 + 1001);
        check("a_busy", bus.busy, 1);
        check("a_active", bus.active_port, 0);
        wait_until(r0 + 2600);
        check("a_connected", bus.connected, 4'hF);
        check("a_overrun", bus.overrun, 0);
        check("a_busy_end", bus.busy, 0);
        check("a_active_hold", bus.active_port, 3);
        check("a_sb_empty", sb.size(), 0);

        // Port 2 silent for three frames, then answers again
        do_reset(16'd1000, 4'hF, r0);
        ans_en = 4'hF;
        push_frame(r0 + 1000, 4'hF, 4'hF);
        push_frame(r0 + 2000, 4'hF, 4'hB);
        push_frame(r0 + 3000, 4'hF, 4'hB);
        push_frame(r0 + 4000, 4'hF, 4'hB);
        push_frame(r0 + 5000, 4'hF, 4'hF);
        wait_until(r0 + 1600);
        ans_en = 4'hB;
        wait_until(r0 + 2645);
        check("b_conn_miss1", bus.connected, 4'hF);
        wait_until(r0 + 4644);
        check("b_conn_before3", bus.connected, 4'hF);
        wait_until(r0 + 4645);
        check("b_conn_after3", bus.connected, 4'hB);
        wait_until(r0 + 4900);
        ans_en = 4'hF;
        wait_until(r0 + 5346);
        check("b_conn_back", bus.connected, 4'hF);
        wait_until(r0 + 5800);
        check("b_sb_empty", sb.size(), 0);

        // Sparse mask: only ports 0 and 2 polled
        do_reset(16'd1000, 4'b0101, r0);
        ans_en = 4'hF;
        push_frame(r0 + 1000, 4'b0101, 4'hF);
        push_frame(r0 + 2000, 4'b0101, 4'hF);
        wait_until(r0 + 2400);
        check("c_connected", bus.connected, 4'b0101);
        check("c_sb_empty", sb.size(), 0);

        // Short period, nobody answers: overrun and back-to-back frames
        do_reset(16'd600, 4'hF, r0);
        ans_en = 4'h0;
        push_frame(r0 + 600, 4'hF, 4'h0);
        push_frame(r0 + 600 + 4 * SPC_MISS + 1, 4'hF, 4'h0);
        push_poll(0, r0 + 600 + 8 * SPC_MISS + 2);
        wait_until(r0 + 1199);
        check("d_overrun_pre", bus.overrun, 0);
        wait_until(r0 + 1200);
        check("d_overrun", bus.overrun, 1);
        wait_until(r0 + 3980);
        check("d_connected", bus.connected, 4'h0);
        check("d_busy", bus.busy, 1);
        check("d_sb_empty", sb.size(), 0);

        // Rumble request changes mid-transaction
        do_reset(16'd1000, 4'hF, r0);
        ans_en = 4'hF;
        push_frame(r0 + 1000, 4'hF, 4'hF);
        push_frame(r0 + 2000, 4'hF, 4'hF);
        wait_until(r0 + 1150);
        bus.rumble_req = 4'b0010;
        wait_until(r0 + 1200);
        check("e_rumble_wait", bus.port_rumble, 4'b0000);
        wait_until(r0 + 2121);
        check("e_rumble_hold", bus.port_rumble, 4'b0000);
        wait_until(r0 + 2122);
        check("e_rumble_issue", bus.port_rumble, 4'b0010);
        wait_until(r0 + 2600);
        check("e_sb_empty", sb.size(), 0);

        // Enable drops during port 1: finish it, no frame_tick, no further polls
        do_reset(16'd1000, 4'hF, r0);
        ans_en = 4'hF;
        push_poll(0, r0 + 1000);
        push_poll(1, r0 + 1000 + SPC_ANS);
        wait_until(r0 + 1150);
        bus.enable = 1'b0;
        wait_until(r0 + 1243);
        check("g_busy_gap", bus.busy, 1);
        wait_until(r0 + 1244);
        check("g_busy_idle", bus.busy, 0);
        check("g_active_hold", bus.active_port, 1);
        wait_until(r0 + 2300);
        check("g_connected", bus.connected, 4'b0011);
        check("g_sb_empty", sb.size(), 0);

        // Reset during port 1 WAIT_DONE, then restart timing from reset release
        do_reset(16'd1000, 4'hF, r0);
        ans_en = 4'hF;
        push_poll(0, r0 + 1000);
        push_poll(1, r0 + 1000 + SPC_ANS);
        wait_until(r0 + 1149);
        check("f_conn_pre", bus.connected, 4'b0001);
        check("f_active_pre", bus.active_port, 1);
        wait_until(r0 + 1150);
        check("f_sb_empty_pre", sb.size(), 0);
        do_reset(16'd1000, 4'hF, r1);
        push_poll(0, r1 + 1000);
        wait_until(r1 + 999);
        check("f_busy_idle", bus.busy, 0);
        wait_until(r1 + 1010);
        check("f_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
